issue_dispatch: RTL and testbench

In-order dual-issue dispatcher that feeds the execution stage's `t_execution[1:0]` bus. It buffers decoded, operand-ready instructions (`to_execution` payloads) in a small circular queue. Each cycle it issues up to two of them from the head to distinct, non-busy functional units, using `busy_fu` from the execution stage and a one-cycle reservation mask. It sits between rename/operand-read and `execution`.

---
 rtl/issue_dispatch.sv | 156 +++++++++++++++
 tb/tb_issue_dispatch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/issue_dispatch.sv
// In-order dual-issue dispatcher: a circular queue of operand-ready instructions
// issued two at a time to distinct, free functional units. Slot layout {valid, fu[1:0], payload}.
module issue_dispatch #(
   parameter int FU_NUMBER   = 4,
   parameter int QUEUE_DEPTH = 4,
   parameter int PAYLOAD_W   = 32,
   parameter int ENTRY_W     = PAYLOAD_W + 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [1:0]           enq_valid,
   input  logic [2*ENTRY_W-1:0] enq_data,
   output logic                 enq_ready,
   input  logic [FU_NUMBER-1:0] busy_fu,
   output logic [2*ENTRY_W-1:0] t_execution,
   output logic [1:0]           issued_count,
   output logic                 empty
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = ENTRY_W - 1;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0] CNT_TWO   = CW'(2'd2);
   localparam logic [CW-1:0] ENQ_LIMIT = CW'(QUEUE_DEPTH - 2);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

   function automatic logic [FU_NUMBER-1:0] fu_onehot(input logic [1:0] fu);
      logic [FU_NUMBER-1:0] oh;
      oh     = {FU_NUMBER{1'b0}};
      oh[fu] = 1'b1;
      return oh;
   endfunction

   function automatic logic [1:0] entry_fu(input logic [SW-1:0] e);
      return e[PAYLOAD_W +: 2];
   endfunction

   function automatic logic [SW-1:0] strip_valid(input logic [ENTRY_W-1:0] e);
      return e[SW-1:0];
   endfunction

   logic [SW-1:0]          mem_q [QUEUE_DEPTH];
   logic [AW-1:0]          head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [FU_NUMBER-1:0]   rsv_q, rsv_d;
   logic [2*ENTRY_W-1:0]   bus_q, bus_d;
   logic [1:0]             icnt_q, icnt_d;

   logic [AW-1:0]          head_nxt_s, tail_nxt_s;
   logic [SW-1:0]          ent0_s, ent1_s;
   logic [1:0]             fu0_s, fu1_s;
   logic [FU_NUMBER-1:0]   free_s;
   logic                   iss0_s, iss1_s;
   logic                   wr0_s, wr1_s;
   logic                   enq_ready_s;
   logic [1:0]             n_enq_s, n_iss_s;
   logic                   unused_valid_s;

   // The valid bits inside enq_data are superseded by enq_valid.
   assign unused_valid_s = enq_data[ENTRY_W-1] ^ enq_data[2*ENTRY_W-1];

   assign head_nxt_s  = head_q + PTR_ONE;
   assign tail_nxt_s  = tail_q + PTR_ONE;
   assign ent0_s      = mem_q[head_q];
   assign ent1_s      = mem_q[head_nxt_s];
   assign fu0_s       = entry_fu(ent0_s);
   assign fu1_s       = entry_fu(ent1_s);
   assign free_s      = ~busy_fu & ~rsv_q;
   assign enq_ready_s = (cnt_q <= ENQ_LIMIT);

   // Enqueue acceptance: only a legal request while two slots are free, never during flush.
   always_comb begin
      wr0_s = 1'b0;
      wr1_s = 1'b0;
      if (enq_ready_s && !flush && enq_valid[0]) begin
         wr0_s = 1'b1;
         wr1_s = enq_valid[1];
      end else begin
         wr0_s = 1'b0;
         wr1_s = 1'b0;
      end
   end

   // Issue decision: strictly in order from the head, distinct free FUs.
   always_comb begin
      iss0_s = (cnt_q >= CNT_ONE) && free_s[fu0_s];
      iss1_s = iss0_s && (cnt_q >= CNT_TWO) && (fu1_s != fu0_s) && free_s[fu1_s];
   end

   assign n_enq_s = {1'b0, wr0_s} + {1'b0, wr1_s};
   assign n_iss_s = {1'b0, iss0_s} + {1'b0, iss1_s};

   // Next-state for pointers, occupancy, reservation and the issue bus; flush wins.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      rsv_d  = rsv_q;
      bus_d  = bus_q;
      icnt_d = icnt_q;
      if (flush) begin
         head_d = {AW{1'b0}};
         tail_d = {AW{1'b0}};
         cnt_d  = {CW{1'b0}};
         rsv_d  = {FU_NUMBER{1'b0}};
         bus_d  = {(2*ENTRY_W){1'b0}};
         icnt_d = 2'd0;
      end else begin
         head_d = head_q + AW'(n_iss_s);
         tail_d = tail_q + AW'(n_enq_s);
         cnt_d  = cnt_q + CW'(n_enq_s) - CW'(n_iss_s);
         // Reservation covers the cycle before busy_fu reflects the new op.
         rsv_d  = (iss0_s ? fu_onehot(fu0_s) : {FU_NUMBER{1'b0}})
                | (iss1_s ? fu_onehot(fu1_s) : {FU_NUMBER{1'b0}});
         bus_d  = {iss1_s, ent1_s, iss0_s, ent0_s};
         icnt_d = n_iss_s;
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= {AW{1'b0}};
         tail_q <= {AW{1'b0}};
         cnt_q  <= {CW{1'b0}};
         rsv_q  <= {FU_NUMBER{1'b0}};
         bus_q  <= {(2*ENTRY_W){1'b0}};
         icnt_q <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         rsv_q  <= rsv_d;
         bus_q  <= bus_d;
         icnt_q <= icnt_d;
      end
   end

   // Queue storage; contents are only meaningful within the occupied range.
   always_ff @(posedge clk) begin
      if (wr0_s) begin
         mem_q[tail_q] <= strip_valid(enq_data[ENTRY_W-1:0]);
      end
      if (wr1_s) begin
         mem_q[tail_nxt_s] <= strip_valid(enq_data[2*ENTRY_W-1:ENTRY_W]);
      end
   end

   assign t_execution  = bus_q;
   assign issued_count = icnt_q;
   assign empty        = (cnt_q == {CW{1'b0}});
   assign enq_ready    = enq_ready_s;

endmodule

// File: tb/tb_issue_dispatch.sv
// Bench for issue_dispatch: per-cycle vector table plus an in-order payload scoreboard.
module tb_issue_dispatch;

   localparam int PW = 32;
   localparam int EW = PW + 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic [1:0]      enq_valid;
   logic [2*EW-1:0] enq_data;
   logic            enq_ready;
   logic [3:0]      busy_fu;
   logic [2*EW-1:0] t_execution;
   logic [1:0]      issued_count;
   logic            empty;

   always #5 clk = ~clk;

   issue_dispatch #(.FU_NUMBER(4), .QUEUE_DEPTH(4), .PAYLOAD_W(PW), .ENTRY_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .enq_valid(enq_valid), .enq_data(enq_data),
      .enq_ready(enq_ready), .busy_fu(busy_fu), .t_execution(t_execution),
      .issued_count(issued_count), .empty(empty)
   );

   typedef struct packed {
      logic [1:0] ev;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [3:0] busy;
      logic       fl;
      logic [1:0] acc;
      logic       v0;
      logic [1:0] f0;
      logic       v1;
      logic [1:0] f1;
      logic [1:0] ic;
      logic       emp;
      logic       rdy;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [33:0] exp_q[$];
   logic [33:0] sb_e;
   logic [31:0] tag;
   vec_t        tbl[22];

   function automatic vec_t mk(input logic [1:0] ev, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [3:0] busy, input logic fl, input logic [1:0] acc,
                               input logic v0, input logic [1:0] f0, input logic v1,
                               input logic [1:0] f1, input logic [1:0] ic, input logic emp,
                               input logic rdy);
      vec_t v;
      v.ev = ev; v.fa = fa; v.fb = fb; v.busy = busy; v.fl = fl; v.acc = acc;
      v.v0 = v0; v.f0 = f0; v.v1 = v1; v.f1 = f1; v.ic = ic; v.emp = emp; v.rdy = rdy;
      return v;
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one vector for one cycle, record accepted entries, then check the registered outputs.
   task automatic run_row(input vec_t v, input string nm);
      enq_valid = v.ev;
      enq_data  = {1'b1, v.fb, tag + 32'd1, 1'b1, v.fa, tag};
      busy_fu   = v.busy;
      flush     = v.fl;
      if (v.acc >= 2'd1) exp_q.push_back({v.fa, tag});
      if (v.acc == 2'd2) exp_q.push_back({v.fb, tag + 32'd1});
      tag = tag + 32'd2;
      step();
      if (v.fl) exp_q.delete();
      check({nm, "_v0"}, t_execution[EW-1], v.v0);
      check({nm, "_v1"}, t_execution[2*EW-1], v.v1);
      if (v.v0) check({nm, "_f0"}, t_execution[PW +: 2], v.f0);
      if (v.v1) check({nm, "_f1"}, t_execution[EW+PW +: 2], v.f1);
      check({nm, "_icnt"}, issued_count, v.ic);
      check({nm, "_empty"}, empty, v.emp);
      check({nm, "_ready"}, enq_ready, v.rdy);
   endtask

   // Scoreboard: every valid issue slot must match the oldest outstanding entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int s = 0; s < 2; s++) begin
            if (t_execution[s*EW + EW - 1]) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL sb_extra_issue: got %0h expected none", t_execution[s*EW +: 34]);
               end else begin
                  sb_e = exp_q.pop_front();
                  check("sb_order", t_execution[s*EW +: 34], sb_e);
               end
            end
         end
      end
   end

   initial begin
      //            ev     fa    fb    busy   fl    acc    v0    f0    v1    f1    ic    emp   rdy
      tbl[0]  = mk(2'b11, 2'd2, 2'd0, 4'h0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[1]  = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 2'd0, 2'd2, 1'b1, 1'b1);
      tbl[2]  = mk(2'b11, 2'd2, 2'd2, 4'h0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[3]  = mk(2'b01, 2'd2, 2'd0, 4'h0, 1'b0, 2'd1, 1'b1, 2'd2, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1);
      tbl[4]  = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[5]  = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1);
      tbl[6]  = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[7]  = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1);
      tbl[8]  = mk(2'b11, 2'd1, 2'd3, 4'h2, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[9]  = mk(2'b00, 2'd0, 2'd0, 4'h2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[10] = mk(2'b00, 2'd0, 2'd0, 4'h2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[11] = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'd3, 2'd2, 1'b1, 1'b1);
      tbl[12] = mk(2'b11, 2'd0, 2'd1, 4'hF, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
      tbl[13] = mk(2'b11, 2'd2, 2'd3, 4'hF, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      tbl[14] = mk(2'b11, 2'd0, 2'd0, 4'hF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
      tbl[15] = mk(2'b00, 2'd0, 2'd0, 4'hE, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0);
      tbl[16] = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b1);
      tbl[17] = mk(2'b11, 2'd1, 2'd2, 4'h0, 1'b0, 2'd2, 1'b1, 2'd3, 1'b0, 2'd0, 2'd1, 1'b0, 1'b1);
      tbl[18] = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1);
      tbl[19] = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
      tbl[20] = mk(2'b10, 2'd1, 2'd1, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);
      tbl[21] = mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1);

      // Reset held two cycles under random stimulus.
      rst_n = 1'b0;
      tag   = 32'd0;
      for (int i = 0; i < 2; i++) begin
         enq_valid = 2'($urandom_range(0, 3));
         enq_data  = {6'($urandom), $urandom, $urandom};
         busy_fu   = 4'($urandom);
         flush     = 1'($urandom_range(0, 1));
         step();
      end
      check("rst_bus", t_execution, 70'd0);
      check("rst_icnt", issued_count, 2'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_ready", enq_ready, 1'b1);

      rst_n     = 1'b1;
      flush     = 1'b0;
      enq_valid = 2'b00;
      enq_data  = '0;
      busy_fu   = 4'h0;
      exp_q.delete();

      for (int i = 0; i < 22; i++) begin
         run_row(tbl[i], $sformatf("r%0d", i));
      end

      // Flush with three queued entries and an issue on the bus, then recovery.
      run_row(mk(2'b11, 2'd1, 2'd0, 4'h0, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1), "fl0");
      run_row(mk(2'b11, 2'd0, 2'd2, 4'h1, 1'b0, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0), "fl1");
      run_row(mk(2'b11, 2'd3, 2'd3, 4'h0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1), "fl2");
      run_row(mk(2'b01, 2'd0, 2'd0, 4'h0, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1), "fl3");
      run_row(mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1), "fl4");
      // Flush on an empty queue must drop the simultaneous enqueue.
      run_row(mk(2'b11, 2'd2, 2'd3, 4'h0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1), "fl5");
      run_row(mk(2'b00, 2'd0, 2'd0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1), "fl6");

      check("sb_drained", 72'(exp_q.size()), 72'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
